// File: rtl/alu_sweep_capture.sv
// Opcode sweeper and response compactor for a 32-bit combinational ALU.
// Steps aluc through all 16 opcodes with fixed operands and folds each settled result into a MISR.
module alu_sweep_capture #(
  parameter int                 WIDTH  = 32,
  parameter logic [WIDTH-1:0]   OP_A   = 32'h00000011,
  parameter logic [WIDTH-1:0]   OP_B   = 32'hfffffffe,
  parameter int                 SETTLE = 2,
  parameter logic [WIDTH+3:0]   POLY   = 36'h000000805
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [3:0]       aluc,
  input  logic [WIDTH-1:0] r,
  input  logic             zero,
  input  logic             negative,
  input  logic             carry,
  input  logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH+3:0] signature,
  output logic [4:0]       sample_count
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       aluc_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH+3:0] sig_q;
  logic [WIDTH+3:0] sig_d;
  logic [4:0]       cnt_smp_q;

  // Galois-style MISR step: shift left, fold the ejected MSB back through POLY, absorb data.
  function automatic logic [WIDTH+3:0] misr_step(input logic [WIDTH+3:0] sig,
                                                 input logic [WIDTH+3:0] data);
    logic [WIDTH+3:0] fb;
    fb = sig[WIDTH+3] ? POLY : {(WIDTH+4){1'b0}};
    return {sig[WIDTH+2:0], 1'b0} ^ fb ^ data;
  endfunction

  assign sig_d = misr_step(sig_q, {overflow, carry, negative, zero, r});

  // Sweep sequencer: every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      aluc_q    <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sig_q     <= {(WIDTH+4){1'b0}};
      cnt_smp_q <= 5'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= APPLY;
            cnt_q     <= {CW{1'b0}};
            a_q       <= OP_A;
            b_q       <= OP_B;
            aluc_q    <= 4'd0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            sig_q     <= {(WIDTH+4){1'b0}};
            cnt_smp_q <= 5'd0;
          end else begin
            state_q <= state_q;
          end
        end
        APPLY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= {CW{1'b0}};
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        SAMPLE: begin
          sig_q     <= sig_d;
          cnt_smp_q <= cnt_smp_q + 5'd1;
          // Opcode 15 exits before the increment, so aluc never wraps.
          if (aluc_q == 4'd15) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            aluc_q  <= aluc_q + 4'd1;
            state_q <= APPLY;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a            = a_q;
  assign b            = b_q;
  assign aluc         = aluc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign signature    = sig_q;
  assign sample_count = cnt_smp_q;

endmodule

// File: tb/tb_alu_sweep_capture.sv
// Directed bench for alu_sweep_capture: a stub ALU whose response pattern is chosen per step,
// with hand-computed signatures and timing checked by immediate assertions.
module tb_alu_sweep_capture;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic [31:0] r;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;
  logic        busy;
  logic        done;
  logic [35:0] signature;
  logic [4:0]  sample_count;

  int n_checks;
  int n_errors;
  int mode;

  alu_sweep_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a            (a),
    .b            (b),
    .aluc         (aluc),
    .r            (r),
    .zero         (zero),
    .negative     (negative),
    .carry        (carry),
    .overflow     (overflow),
    .busy         (busy),
    .done         (done),
    .signature    (signature),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU: 0 all zero, 1 r=1, 2 overflow on opcode 0 only, 3 flag impulses near the end.
  always_comb begin
    r        = 32'd0;
    zero     = 1'b0;
    negative = 1'b0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (mode)
      1: r = 32'd1;
      2: overflow = (aluc == 4'd0);
      3: begin
        zero     = (aluc == 4'd13);
        carry    = (aluc == 4'd14);
        negative = (aluc == 4'd15);
        r        = (aluc == 4'd15) ? 32'd3 : 32'd0;
      end
      default: r = 32'd0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && done !== 1'b1; i++) tick();
    check("done_within_bound", {63'd0, done}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a"}, {32'd0, a}, 64'd0);
    check({tag, "_b"}, {32'd0, b}, 64'd0);
    check({tag, "_aluc"}, {60'd0, aluc}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_sig"}, {28'd0, signature}, 64'd0);
    check({tag, "_cnt"}, {59'd0, sample_count}, 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mode     = 0;
    start    = 1'b0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_reset_outputs("idle");

    // Full sweep with r=1: sequencing, timing and the ones-data signature.
    mode = 1;
    pulse_start();
    check("st_aluc", {60'd0, aluc}, 64'd0);
    check("st_busy", {63'd0, busy}, 64'd1);
    check("st_done", {63'd0, done}, 64'd0);
    check("st_a", {32'd0, a}, 64'h11);
    check("st_b", {32'd0, b}, 64'hfffffffe);
    check("st_cnt", {59'd0, sample_count}, 64'd0);
    for (int n = 1; n < 48; n++) begin
      tick();
      check("seq_aluc", {60'd0, aluc}, 64'(n / 3));
      check("seq_cnt", {59'd0, sample_count}, 64'(n / 3));
      check("seq_done", {63'd0, done}, 64'd0);
      check("seq_a", {32'd0, a}, 64'h11);
      check("seq_b", {32'd0, b}, 64'hfffffffe);
      if (n == 3) check("ones_s1", {28'd0, signature}, 64'h1);
      if (n == 12) check("ones_s4", {28'd0, signature}, 64'hf);
      if (n == 47) start = 1'b1;
    end
    tick();
    start = 1'b0;
    check("end_done", {63'd0, done}, 64'd1);
    check("end_busy", {63'd0, busy}, 64'd0);
    check("end_cnt", {59'd0, sample_count}, 64'd16);
    check("end_aluc", {60'd0, aluc}, 64'd15);
    check("ones_sig", {28'd0, signature}, 64'h00000ffff);
    tick();
    check("done_edge_start_ignored", {63'd0, done}, 64'd1);
    check("done_hold_aluc", {60'd0, aluc}, 64'd15);
    check("done_hold_a", {32'd0, a}, 64'h11);

    // Restart from DONE with zero data; start during SAMPLE and APPLY must be ignored.
    mode = 0;
    pulse_start();
    check("rs_sig_clr", {28'd0, signature}, 64'd0);
    check("rs_aluc", {60'd0, aluc}, 64'd0);
    check("rs_done", {63'd0, done}, 64'd0);
    check("rs_busy", {63'd0, busy}, 64'd1);
    tick();
    tick();
    pulse_start();
    check("ign_sample_aluc", {60'd0, aluc}, 64'd1);
    check("ign_sample_cnt", {59'd0, sample_count}, 64'd1);
    pulse_start();
    check("ign_apply_aluc", {60'd0, aluc}, 64'd1);
    check("ign_apply_cnt", {59'd0, sample_count}, 64'd1);
    wait_done();
    check("zero_sig", {28'd0, signature}, 64'd0);
    check("zero_cnt", {59'd0, sample_count}, 64'd16);

    // Feedback: MSB set by the first sample is folded back through POLY on the second.
    mode = 2;
    pulse_start();
    tick(); tick(); tick();
    check("fb_s1", {28'd0, signature}, 64'h800000000);
    tick(); tick(); tick();
    check("fb_s2", {28'd0, signature}, 64'h000000805);
    wait_done();
    check("fb_final", {28'd0, signature}, 64'h002014000);

    // Flag ordering: zero@13, carry@14, negative+r=3@15.
    mode = 3;
    pulse_start();
    wait_done();
    check("flags_final", {28'd0, signature}, 64'he00000003);

    // Asynchronous abort during opcode 7, then a clean restart.
    mode = 1;
    pulse_start();
    for (int i = 0; i < 22; i++) tick();
    check("abort_pre_aluc", {60'd0, aluc}, 64'd7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("abort_stay_idle", {63'd0, busy}, 64'd0);
    check("abort_stay_aluc", {60'd0, aluc}, 64'd0);
    pulse_start();
    check("post_abort_busy", {63'd0, busy}, 64'd1);
    wait_done();
    check("post_abort_sig", {28'd0, signature}, 64'h00000ffff);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
